cmd_stream_parser: RTL and testbench

- Parametrised byte-stream command parser for the header-plus-operand command format: header[7:6] selects the class, 00 = CPU and 01 = MEM; header[5:0] is the opcode.
- Accepts bytes over a valid/ready input, tracks per-command length, and assembles operands big-endian.
- Executes CPU ADD/SUB in place. Emits one decoded result record per command over a valid/ready output.
- Generalises the fixed 1-byte-operand / 2-byte-address format via OPND_BYTES and ADDR_BYTES. Adds illegal-command detection, an error counter, and backpressure.

---
 rtl/cmd_stream_parser_if.sv | 35 +++
 rtl/cmd_stream_parser.sv | 164 ++++++++++++++++
 tb/tb_cmd_stream_parser.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_stream_parser_if.sv
// Byte-in / record-out handshake bundle for the command stream parser.
interface cmd_stream_parser_if #(
   parameter int OPND_BYTES = 1,
   parameter int ADDR_BYTES = 2,
   parameter int ERR_CNT_W  = 16
);
   localparam int OPND_W = 8 * OPND_BYTES;
   localparam int ADDR_W = 8 * ADDR_BYTES;

   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [1:0]           out_class;
   logic [5:0]           out_opcode;
   logic [OPND_W:0]      out_result;
   logic [7:0]           out_reg;
   logic [ADDR_W-1:0]    out_addr_a;
   logic [ADDR_W-1:0]    out_addr_b;
   logic                 out_err;
   logic [ERR_CNT_W-1:0] err_count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_class, out_opcode, out_result,
             out_reg, out_addr_a, out_addr_b, out_err, err_count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_class, out_opcode, out_result,
             out_reg, out_addr_a, out_addr_b, out_err, err_count
   );
endinterface

// File: rtl/cmd_stream_parser.sv
// Header-plus-operand command parser: collects bytes, decodes CPU/MEM commands,
// executes ADD/SUB and emits one result record per command.
module cmd_stream_parser #(
   parameter int OPND_BYTES = 1,
   parameter int ADDR_BYTES = 2,
   parameter int ERR_CNT_W  = 16
) (
   input logic               clk,
   input logic               rst_n,
   cmd_stream_parser_if.slave bus
);
   localparam int OPND_W   = 8 * OPND_BYTES;
   localparam int ADDR_W   = 8 * ADDR_BYTES;
   localparam int PL_A     = 2 * OPND_BYTES;
   localparam int PL_C     = 2 * ADDR_BYTES;
   localparam int PL_BYTES = (PL_A > PL_C) ? PL_A : PL_C;
   localparam int PL_W     = 8 * PL_BYTES;
   localparam int CNT_W    = $clog2(PL_BYTES) + 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} state_t;

   state_t               state_q, state_d;
   logic                 rdy_en_q;
   logic [1:0]           cls_q, cls_d;
   logic [5:0]           opc_q, opc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PL_W-1:0]      pl_q, pl_d;
   logic [OPND_W:0]      res_q, res_d;
   logic [7:0]           reg_q, reg_d;
   logic [ADDR_W-1:0]    addr_a_q, addr_a_d;
   logic [ADDR_W-1:0]    addr_b_q, addr_b_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic in_ready_s;
   logic in_fire;
   logic legal;
   logic done;

   // rdy_en_q keeps in_ready low through reset and for no longer than one clock after it.
   assign in_ready_s = rdy_en_q && (state_q != S_EMIT);
   assign in_fire    = bus.in_valid && in_ready_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rdy_en_q  <= 1'b0;
         cls_q     <= '0;
         opc_q     <= '0;
         cnt_q     <= '0;
         pl_q      <= '0;
         res_q     <= '0;
         reg_q     <= '0;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rdy_en_q  <= 1'b1;
         cls_q     <= cls_d;
         opc_q     <= opc_d;
         cnt_q     <= cnt_d;
         pl_q      <= pl_d;
         res_q     <= res_d;
         reg_q     <= reg_d;
         addr_a_q  <= addr_a_d;
         addr_b_q  <= addr_b_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      opc_d     = opc_q;
      cnt_d     = cnt_q;
      pl_d      = pl_q;
      res_d     = res_q;
      reg_d     = reg_q;
      addr_a_d  = addr_a_q;
      addr_b_d  = addr_b_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_fire) begin
               cls_d = bus.in_data[7:6];
               opc_d = bus.in_data[5:0];
               pl_d  = '0;
            end
         end
         S_COLLECT: begin
            if (in_fire) begin
               pl_d  = {pl_q[PL_W-9:0], bus.in_data};
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_EMIT: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      legal = ((cls_d == 2'b00) && (opc_d <= 6'd2)) ||
              ((cls_d == 2'b01) && (opc_d <= 6'd3));

      if ((state_q == S_IDLE) && in_fire) begin
         if (!legal) begin
            done = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
         end else if (opc_d == 6'd0) begin
            done = 1'b1;
         end else begin
            // Counter holds payload bytes still to come minus one.
            state_d = S_COLLECT;
            if (cls_d == 2'b00)     cnt_d = CNT_W'(2 * OPND_BYTES - 1);
            else if (opc_d == 6'd3) cnt_d = CNT_W'(2 * ADDR_BYTES - 1);
            else                    cnt_d = CNT_W'(ADDR_BYTES);
         end
      end

      if ((state_q == S_COLLECT) && in_fire && (cnt_q == '0)) done = 1'b1;

      // Payload is right-aligned in pl_d, so fields are sliced from the low end.
      if (done) begin
         state_d  = S_EMIT;
         err_d    = !legal;
         res_d    = '0;
         reg_d    = '0;
         addr_a_d = '0;
         addr_b_d = '0;
         if (legal) begin
            case ({cls_d, opc_d})
               8'h01: res_d = {1'b0, pl_d[2*OPND_W-1:OPND_W]} + {1'b0, pl_d[OPND_W-1:0]};
               8'h02: res_d = {1'b0, pl_d[2*OPND_W-1:OPND_W]} - {1'b0, pl_d[OPND_W-1:0]};
               8'h41, 8'h42: begin
                  reg_d    = pl_d[ADDR_W+7:ADDR_W];
                  addr_a_d = pl_d[ADDR_W-1:0];
               end
               8'h43: begin
                  addr_a_d = pl_d[2*ADDR_W-1:ADDR_W];
                  addr_b_d = pl_d[ADDR_W-1:0];
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = (state_q == S_EMIT);
   assign bus.out_class  = cls_q;
   assign bus.out_opcode = opc_q;
   assign bus.out_result = res_q;
   assign bus.out_reg    = reg_q;
   assign bus.out_addr_a = addr_a_q;
   assign bus.out_addr_b = addr_b_q;
   assign bus.out_err    = err_q;
   assign bus.err_count  = err_cnt_q;
endmodule

// File: tb/tb_cmd_stream_parser.sv
// Scoreboard bench for cmd_stream_parser: default-width and wide-operand instances
// driven from a value-level command model.
module tb_cmd_stream_parser;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cmd_stream_parser_if #(.OPND_BYTES(1), .ADDR_BYTES(2), .ERR_CNT_W(16)) ifa ();
   cmd_stream_parser_if #(.OPND_BYTES(2), .ADDR_BYTES(3), .ERR_CNT_W(16)) ifb ();

   cmd_stream_parser #(.OPND_BYTES(1), .ADDR_BYTES(2), .ERR_CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa));
   cmd_stream_parser #(.OPND_BYTES(2), .ADDR_BYTES(3), .ERR_CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   typedef struct packed {
      logic [1:0]  cls;
      logic [5:0]  opc;
      logic [63:0] res;
      logic [7:0]  rg;
      logic [63:0] a;
      logic [63:0] b;
      logic        err;
   } rec_t;

   int   errors = 0;
   int   checks = 0;
   rec_t expq_a[$];
   rec_t expq_b[$];
   int   err_exp[2] = '{0, 0};
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held off
   bit   gap_en = 1'b0;
   bit   bp_done;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_rec(input string name, input rec_t got, input rec_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got cls=%0h opc=%0h res=%0h reg=%0h a=%0h b=%0h err=%0b expected cls=%0h opc=%0h res=%0h reg=%0h a=%0h b=%0h err=%0b",
                  name, got.cls, got.opc, got.res, got.rg, got.a, got.b, got.err,
                  exp.cls, exp.opc, exp.res, exp.rg, exp.a, exp.b, exp.err);
      end else begin
         $display("record %s: cls=%0h opc=%0h res=%0h reg=%0h a=%0h b=%0h err=%0b",
                  name, got.cls, got.opc, got.res, got.rg, got.a, got.b, got.err);
      end
   endtask

   function automatic rec_t grab(input int w);
      rec_t r;
      if (w == 0) begin
         r = '{ifa.out_class, ifa.out_opcode, 64'(ifa.out_result), ifa.out_reg,
               64'(ifa.out_addr_a), 64'(ifa.out_addr_b), ifa.out_err};
      end else begin
         r = '{ifb.out_class, ifb.out_opcode, 64'(ifb.out_result), ifb.out_reg,
               64'(ifb.out_addr_a), 64'(ifb.out_addr_b), ifb.out_err};
      end
      return r;
   endfunction

   // Monitors: compare on transfer, and check the record stays put while stalled.
   rec_t prev_a, prev_b, g_a, g_b;
   bit   stall_a = 1'b0, stall_b = 1'b0;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && ifa.out_valid === 1'b1) begin
         g_a = grab(0);
         if (stall_a) chk_rec("hold_a", g_a, prev_a);
         chk("in_ready_in_emit_a", 64'(ifa.in_ready), 64'd0);
         if (ifa.out_ready) begin
            if (expq_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rec_a: got opc=%0h expected no record", g_a.opc);
            end else chk_rec("rec_a", g_a, expq_a.pop_front());
            stall_a = 1'b0;
         end else begin
            stall_a = 1'b1;
            prev_a  = g_a;
         end
      end else stall_a = 1'b0;
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && ifb.out_valid === 1'b1) begin
         g_b = grab(1);
         if (stall_b) chk_rec("hold_b", g_b, prev_b);
         if (ifb.out_ready) begin
            if (expq_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rec_b: got opc=%0h expected no record", g_b.opc);
            end else chk_rec("rec_b", g_b, expq_b.pop_front());
            stall_b = 1'b0;
         end else begin
            stall_b = 1'b1;
            prev_b  = g_b;
         end
      end else stall_b = 1'b0;
   end

   initial begin
      logic r;
      ifa.out_ready = 1'b0;
      ifb.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
         ifa.out_ready = r;
         ifb.out_ready = r;
      end
   end

   task automatic set_in(input int w, input logic v, input logic [7:0] d);
      if (w == 0) begin ifa.in_valid = v; ifa.in_data = d; end
      else        begin ifb.in_valid = v; ifb.in_data = d; end
   endtask

   function automatic logic in_rdy(input int w);
      return (w == 0) ? ifa.in_ready : ifb.in_ready;
   endfunction

   // Returns just after the rising edge that accepted the byte.
   task automatic send_byte(input int w, input logic [7:0] b);
      int t;
      @(negedge clk);
      if (gap_en && $urandom_range(0, 3) == 0) begin
         set_in(w, 1'b0, 8'h00);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      set_in(w, 1'b1, b);
      t = 0;
      while (!in_rdy(w) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         checks++; errors++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 500 cycles");
      end
      @(posedge clk);
   endtask

   // Builds the byte stream and the expected record from command-level values.
   task automatic issue(input int w, input logic [7:0] hdr, input logic [63:0] v1, input logic [63:0] v2);
      int          ob = (w == 0) ? 1 : 2;
      int          ab = (w == 0) ? 2 : 3;
      logic [63:0] om = (64'd1 << (8 * ob)) - 64'd1;
      logic [63:0] rm = (64'd1 << (8 * ob + 1)) - 64'd1;
      logic [63:0] am = (64'd1 << (8 * ab)) - 64'd1;
      logic [1:0]  cls = hdr[7:6];
      logic [5:0]  opc = hdr[5:0];
      logic [7:0]  bq[$];
      rec_t        e = '0;
      e.cls = cls;
      e.opc = opc;
      bq.push_back(hdr);
      if (!((cls == 2'd0 && opc <= 6'd2) || (cls == 2'd1 && opc <= 6'd3))) begin
         e.err = 1'b1;
         err_exp[w]++;
      end else if (cls == 2'd0 && opc != 6'd0) begin
         for (int i = ob - 1; i >= 0; i--) bq.push_back(8'(v1 >> (8 * i)));
         for (int i = ob - 1; i >= 0; i--) bq.push_back(8'(v2 >> (8 * i)));
         e.res = (opc == 6'd1) ? ((v1 & om) + (v2 & om)) : (((v1 & om) - (v2 & om)) & rm);
      end else if (cls == 2'd1 && (opc == 6'd1 || opc == 6'd2)) begin
         bq.push_back(v1[7:0]);
         for (int i = ab - 1; i >= 0; i--) bq.push_back(8'(v2 >> (8 * i)));
         e.rg = v1[7:0];
         e.a  = v2 & am;
      end else if (cls == 2'd1 && opc == 6'd3) begin
         for (int i = ab - 1; i >= 0; i--) bq.push_back(8'(v1 >> (8 * i)));
         for (int i = ab - 1; i >= 0; i--) bq.push_back(8'(v2 >> (8 * i)));
         e.a = v1 & am;
         e.b = v2 & am;
      end
      if (w == 0) expq_a.push_back(e);
      else        expq_b.push_back(e);
      foreach (bq[i]) send_byte(w, bq[i]);
      @(negedge clk);
      set_in(w, 1'b0, 8'h00);
   endtask

   task automatic rand_cmd(input int w);
      logic [7:0]  hdr;
      logic [63:0] v1 = {$urandom, $urandom};
      logic [63:0] v2 = {$urandom, $urandom};
      case ($urandom_range(0, 11))
         0:  hdr = 8'h00;
         1, 8, 9:   hdr = 8'h01;
         2, 10, 11: hdr = 8'h02;
         3:  hdr = 8'h40;
         4:  hdr = 8'h41;
         5:  hdr = 8'h42;
         6:  hdr = 8'h43;
         default: begin
            case ($urandom_range(0, 3))
               0: hdr = {2'b10, 6'($urandom)};
               1: hdr = {2'b11, 6'($urandom)};
               2: hdr = {2'b00, 6'($urandom_range(3, 63))};
               default: hdr = {2'b01, 6'($urandom_range(4, 63))};
            endcase
         end
      endcase
      issue(w, hdr, v1, v2);
   endtask

   task automatic drain();
      int t = 0;
      while ((expq_a.size() != 0 || expq_b.size() != 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending records expected 0",
                  expq_a.size(), expq_b.size());
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(0, 1'b0, 8'h00);
      set_in(1, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      chk("rst_in_ready_a", 64'(ifa.in_ready), 64'd0);
      chk("rst_in_ready_b", 64'(ifb.in_ready), 64'd0);
      chk("rst_out_valid_a", 64'(ifa.out_valid), 64'd0);
      chk("rst_err_count_a", 64'(ifa.err_count), 64'd0);
      chk("rst_fields_a", {ifa.out_class, ifa.out_opcode, ifa.out_err, 7'd0, ifa.out_result},
          64'd0);
      chk("rst_addr_a", {ifa.out_addr_a, ifa.out_addr_b, ifa.out_reg}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready_a", 64'(ifa.in_ready), 64'd1);

      // Directed commands on the default-width instance.
      issue(0, 8'h01, 64'h05, 64'h03);
      chk("add_latency", 64'(ifa.out_valid), 64'd1);
      issue(0, 8'h02, 64'h03, 64'h05);
      issue(0, 8'h01, 64'hFF, 64'hFF);
      issue(0, 8'h00, 64'h0, 64'h0);
      issue(0, 8'h41, 64'h07, 64'h1234);
      issue(0, 8'h43, 64'hABCD, 64'h0102);
      issue(0, 8'h40, 64'h0, 64'h0);
      issue(0, 8'h85, 64'h0, 64'h0);
      issue(0, 8'hC0, 64'h0, 64'h0);
      issue(0, 8'h05, 64'h0, 64'h0);
      issue(0, 8'h44, 64'h0, 64'h0);
      issue(0, 8'h00, 64'h0, 64'h0);
      drain();
      chk("err_count_illegal", 64'(ifa.err_count), 64'(err_exp[0]));

      // Backpressure: record held while the next header waits at the input.
      rdy_mode = 2;
      issue(0, 8'h01, 64'h10, 64'h20);
      bp_done = 1'b0;
      fork
         begin
            issue(0, 8'h00, 64'h0, 64'h0);
            bp_done = 1'b1;
         end
      join_none
      repeat (5) begin
         chk("bp_out_valid", 64'(ifa.out_valid), 64'd1);
         chk("bp_in_ready", 64'(ifa.in_ready), 64'd0);
         chk("bp_result", 64'(ifa.out_result), 64'h030);
         @(negedge clk);
      end
      rdy_mode = 0;
      for (int t = 0; t < 200 && !bp_done; t++) @(negedge clk);
      chk("bp_next_cmd_done", 64'(bp_done), 64'd1);
      drain();

      // Random commands with input gaps and random output backpressure.
      rdy_mode = 1;
      gap_en   = 1'b1;
      repeat (80) rand_cmd(0);
      drain();
      gap_en   = 1'b0;
      rdy_mode = 0;
      chk("err_count_random", 64'(ifa.err_count), 64'(err_exp[0]));

      // Reset in the middle of a COPY, then a clean ADD.
      send_byte(0, 8'h43);
      send_byte(0, 8'hAB);
      @(negedge clk);
      set_in(0, 1'b0, 8'h00);
      rst_n = 1'b0;
      err_exp = '{0, 0};
      repeat (2) @(negedge clk);
      chk("midrst_in_ready", 64'(ifa.in_ready), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      issue(0, 8'h01, 64'h01, 64'h01);
      drain();
      chk("midrst_err_count", 64'(ifa.err_count), 64'd0);

      // Wide-operand instance.
      issue(1, 8'h01, 64'hFFFF, 64'h0001);
      issue(1, 8'h43, 64'h123456, 64'hABCDEF);
      issue(1, 8'h02, 64'h0001, 64'h0002);
      issue(1, 8'h41, 64'h5A, 64'h0BEEF1);
      rdy_mode = 1;
      gap_en   = 1'b1;
      repeat (20) rand_cmd(1);
      drain();
      rdy_mode = 0;
      gap_en   = 1'b0;
      chk("err_count_b", 64'(ifb.err_count), 64'(err_exp[1]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish before 2 ms");
      $fatal(1);
   end
endmodule
